// File: rtl/core_kij_sequencer_if.sv
// core_kij_sequencer_if: start/status handshake and the 34-bit core inst bus.
// The sequencer drives the master side; the core/bench sits on the slave side.
interface core_kij_sequencer_if;
  logic        start;
  logic        l0_o_full;
  logic        ofifo_o_valid;
  logic [33:0] inst;
  logic        busy;
  logic        done;
  logic [3:0]  kij;

  modport master (
    input  start, l0_o_full, ofifo_o_valid,
    output inst, busy, done, kij
  );

  modport slave (
    output start, l0_o_full, ofifo_o_valid,
    input  inst, busy, done, kij
  );
endinterface

// File: rtl/core_kij_sequencer.sv
// core_kij_sequencer: sequences one conv tile over all kij passes on the core inst bus.
// Optional SEQ_ACC_EN adds a pmem accumulate pass (ACC) after the last kij.
module core_kij_sequencer #(
  parameter int          COL     = 8,
  parameter int          ROW     = 8,
  parameter int          LEN_NIJ = 36,
  parameter int          LEN_KIJ = 9,
  parameter logic [10:0] W_BASE  = 11'h400,
  parameter logic [10:0] A_BASE  = 11'h000,
  parameter int          GAP     = 10
`ifdef SEQ_ACC_EN
  ,
  parameter int LEN_ONIJ     = 16,
  parameter int O_NI_DIM     = 4,
  parameter int A_PAD_NI_DIM = 6,
  parameter int KI_DIM       = 3
`endif
) (
  input logic                  clk,
  input logic                  reset,
  core_kij_sequencer_if.master bus
);

  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

`ifdef SEQ_ACC_EN
  typedef enum logic [3:0] {
    S_IDLE, S_WL0, S_WPE, S_WGAP, S_AL0,
    S_EXE, S_PS, S_NXT, S_ACC, S_FIN
  } state_t;
`else
  typedef enum logic [3:0] {
    S_IDLE, S_WL0, S_WPE, S_WGAP, S_AL0,
    S_EXE, S_PS, S_NXT, S_FIN
  } state_t;
`endif

  state_t      r_st, w_ns;
  logic [7:0]  r_t, w_nt;
  logic [3:0]  r_kij, w_nkij;
  logic        r_adv, w_adv;
  logic        r_pend, w_pend;
  logic [33:0] r_inst, w_inst;
  logic        r_busy, r_done;
  logic [10:0] w_wbase, w_pbase;
`ifdef SEQ_ACC_EN
  logic [4:0]  r_o, w_no;
  logic [10:0] w_aa;
`endif

  // r_t/r_adv describe the cycle now on the bus; r_adv=0 means it was held
  always_comb begin
    w_ns   = r_st;
    w_nt   = r_t + 8'd1;
    w_nkij = r_kij;
`ifdef SEQ_ACC_EN
    w_no   = r_o;
`endif
    unique case (r_st)
      S_IDLE: begin
        w_nt = '0;
        if (bus.start) begin
          w_ns   = S_WL0;
          w_nkij = '0;
        end
      end
      S_WL0:
        if (r_t == 8'(COL)) begin
          w_ns = S_WPE;
          w_nt = '0;
        end
      S_WPE:
        if (r_t == 8'(COL - 1)) begin
          w_ns = S_WGAP;
          w_nt = '0;
        end
      S_WGAP:
        if (r_t == 8'(GAP - 1)) begin
          w_ns = S_AL0;
          w_nt = '0;
        end
      S_AL0:
        if (!r_adv) w_nt = r_t;
        else if (r_t == 8'(LEN_NIJ)) begin
          w_ns = S_EXE;
          w_nt = '0;
        end
      S_EXE:
        if (r_t == 8'(LEN_NIJ + ROW + COL - 1)) begin
          w_ns = S_PS;
          w_nt = '0;
        end
      S_PS:
        if (!r_adv) w_nt = r_t;
        else if (r_t == 8'(LEN_NIJ - 1)) begin
          w_ns = S_NXT;
          w_nt = '0;
        end
      S_NXT: begin
        w_nt = '0;
        if (r_kij == 4'(LEN_KIJ - 1)) begin
`ifdef SEQ_ACC_EN
          w_ns = S_ACC;
          w_no = '0;
`else
          w_ns = S_FIN;
`endif
        end else begin
          w_ns   = S_WL0;
          w_nkij = r_kij + 4'd1;
        end
      end
`ifdef SEQ_ACC_EN
      S_ACC:
        if (r_t == 8'(LEN_KIJ)) begin
          w_nt = '0;
          if (r_o == 5'(LEN_ONIJ - 1)) w_ns = S_FIN;
          else w_no = r_o + 5'd1;
        end
`endif
      S_FIN: begin
        w_ns   = S_IDLE;
        w_nt   = '0;
        w_nkij = '0;
      end
      default: w_ns = S_IDLE;
    endcase
    w_adv = 1'b1;
    if (w_ns == S_AL0) w_adv = !bus.l0_o_full;
    else if (w_ns == S_PS) w_adv = bus.ofifo_o_valid;
  end

  assign w_wbase = W_BASE + 11'(w_nkij) * 11'(COL);
  assign w_pbase = 11'(w_nkij) * 11'(LEN_NIJ);
`ifdef SEQ_ACC_EN
  assign w_aa = 11'(int'(w_no) / O_NI_DIM * A_PAD_NI_DIM
              + int'(w_no) % O_NI_DIM
              + int'(w_nt) / KI_DIM * A_PAD_NI_DIM
              + int'(w_nt) % KI_DIM
              + int'(w_nt) * LEN_NIJ);
`endif

  // xmem Q holds while CEN=1, so a stalled read's l0_wr just waits
  always_comb begin
    w_inst = IDLE_INST;
    w_pend = 1'b0;
    unique case (w_ns)
      S_WL0: begin
        if (w_nt < 8'(COL)) begin
          w_inst[19]   = 1'b0;
          w_inst[17:7] = w_wbase + 11'(w_nt);
          w_pend       = 1'b1;
        end
        w_inst[2] = r_pend;
      end
      S_WPE: begin
        w_inst[3] = 1'b1;
        w_inst[0] = 1'b1;
      end
      S_AL0:
        if (!w_adv) begin
          w_inst[17:7] = r_inst[17:7];
          w_pend       = r_pend;
        end else begin
          if (w_nt < 8'(LEN_NIJ)) begin
            w_inst[19]   = 1'b0;
            w_inst[17:7] = A_BASE + 11'(w_nt);
            w_pend       = 1'b1;
          end
          w_inst[2] = r_pend;
        end
      S_EXE: begin
        w_inst[3] = 1'b1;
        w_inst[1] = 1'b1;
      end
      S_PS: begin
        w_inst[30:20] = w_pbase + 11'(w_nt);
        if (w_adv) begin
          w_inst[6]  = 1'b1;
          w_inst[32] = 1'b0;
          w_inst[31] = 1'b0;
        end
      end
`ifdef SEQ_ACC_EN
      S_ACC: begin
        if (w_nt < 8'(LEN_KIJ)) begin
          w_inst[32]    = 1'b0;
          w_inst[30:20] = w_aa;
        end
        w_inst[33] = (w_nt != 8'd0);
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st   <= S_IDLE;
      r_t    <= '0;
      r_kij  <= '0;
      r_adv  <= 1'b0;
      r_pend <= 1'b0;
      r_inst <= IDLE_INST;
      r_busy <= 1'b0;
      r_done <= 1'b0;
`ifdef SEQ_ACC_EN
      r_o    <= '0;
`endif
    end else begin
      r_st   <= w_ns;
      r_t    <= w_nt;
      r_kij  <= w_nkij;
      r_adv  <= w_adv;
      r_pend <= w_pend;
      r_inst <= w_inst;
      r_busy <= (w_ns != S_IDLE) && (w_ns != S_FIN);
      r_done <= (w_ns == S_FIN);
`ifdef SEQ_ACC_EN
      r_o    <= w_no;
`endif
    end
  end

  assign bus.inst = r_inst;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.kij  = r_kij;

endmodule
